// File: rtl/present_arb_if.sv
// Requester, response and cipher-core signals of the PRESENT arbiter.
// The arbiter uses the slave modport; requesters and the core sit on the master side.
interface present_arb_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [63:0] req0_data;
    logic [63:0] req1_data;
    logic [79:0] req0_key;
    logic [79:0] req1_key;
    logic        req0_mode;
    logic        req1_mode;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic        rsp0_ready;
    logic        rsp1_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic [63:0] core_idat;
    logic [79:0] core_key;
    logic        core_load;
    logic        core_control;
    logic [63:0] core_odat;
    logic        core_done;
    logic        busy;
    logic        grant;

    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data, req0_key, req1_key,
        input  req0_mode, req1_mode, rsp0_ready, rsp1_ready, core_odat, core_done,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
        output core_idat, core_key, core_load, core_control, busy, grant
    );

    modport master (
        output req0_valid, req1_valid, req0_data, req1_data, req0_key, req1_key,
        output req0_mode, req1_mode, rsp0_ready, rsp1_ready, core_odat, core_done,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
        input  core_idat, core_key, core_load, core_control, busy, grant
    );
endinterface

// File: rtl/present_arb.sv
// Two-requester round-robin front end for a PRESENT cipher core, with a
// per-block BUSY timeout that returns an error response instead of hanging.
module present_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          iReset_n,
    present_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      state_r;
    state_t      state_s;
    logic        last_grant_r;
    logic        grant_r;
    logic        win_s;
    logic        take_s;
    logic        ctrl_r;
    logic        err_r;
    logic        load_r;
    logic        busy_r;
    logic        abort_s;
    logic        rsp_take_s;
    logic [1:0]  rsp_valid_r;
    logic [63:0] idat_r;
    logic [63:0] rsp_data_r;
    logic [79:0] key_r;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_inc_s;

    // Winner selection in IDLE; a tie goes to the requester that was not served last.
    always_comb begin
        take_s = 1'b0;
        win_s  = 1'b0;
        if ((state_r == IDLE) && (bus.req0_valid || bus.req1_valid)) begin
            take_s = 1'b1;
            if (bus.req0_valid && bus.req1_valid) begin
                win_s = ~last_grant_r;
            end else begin
                win_s = bus.req1_valid;
            end
        end else begin
            take_s = 1'b0;
            win_s  = 1'b0;
        end
    end

    assign cnt_inc_s  = (cnt_r == 8'hFF) ? cnt_r : (cnt_r + 8'd1);
    assign abort_s    = (cnt_inc_s == TMO);
    assign rsp_take_s = grant_r ? bus.rsp1_ready : bus.rsp0_ready;

    // Next-state logic; core_done is only looked at while BUSY and wins over the timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (take_s) state_s = LOAD;
                else        state_s = IDLE;
            end
            LOAD: state_s = BUSY;
            BUSY: begin
                if (bus.core_done)  state_s = RESP;
                else if (abort_s)   state_s = RESP;
                else                state_s = BUSY;
            end
            RESP: begin
                if (rsp_take_s) state_s = IDLE;
                else            state_s = RESP;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) state_r <= IDLE;
        else           state_r <= state_s;
    end

    // Request capture, core drive, timeout counter and response registers.
    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            idat_r       <= 64'd0;
            key_r        <= 80'd0;
            ctrl_r       <= 1'b0;
            load_r       <= 1'b0;
            busy_r       <= 1'b0;
            cnt_r        <= 8'd0;
            rsp_data_r   <= 64'd0;
            err_r        <= 1'b0;
            rsp_valid_r  <= 2'b00;
        end else begin
            load_r <= take_s;
            busy_r <= (state_s != IDLE);
            if (take_s) begin
                grant_r <= win_s;
                idat_r  <= win_s ? bus.req1_data : bus.req0_data;
                key_r   <= win_s ? bus.req1_key  : bus.req0_key;
                ctrl_r  <= win_s ? bus.req1_mode : bus.req0_mode;
            end
            case (state_r)
                LOAD: cnt_r <= 8'd0;
                BUSY: begin
                    cnt_r <= cnt_inc_s;
                    if (bus.core_done) begin
                        rsp_data_r  <= bus.core_odat;
                        err_r       <= 1'b0;
                        rsp_valid_r <= grant_r ? 2'b10 : 2'b01;
                    end else if (abort_s) begin
                        rsp_data_r  <= 64'd0;
                        err_r       <= 1'b1;
                        rsp_valid_r <= grant_r ? 2'b10 : 2'b01;
                    end
                end
                RESP: begin
                    if (rsp_take_s) begin
                        rsp_valid_r  <= 2'b00;
                        last_grant_r <= grant_r;
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign bus.req0_ready   = take_s & ~win_s;
    assign bus.req1_ready   = take_s &  win_s;
    assign bus.rsp0_valid   = rsp_valid_r[0];
    assign bus.rsp1_valid   = rsp_valid_r[1];
    assign bus.rsp_data     = rsp_data_r;
    assign bus.rsp_err      = err_r;
    assign bus.core_idat    = idat_r;
    assign bus.core_key     = key_r;
    assign bus.core_load    = load_r;
    assign bus.core_control = ctrl_r;
    assign bus.busy         = busy_r;
    assign bus.grant        = grant_r;
endmodule

// File: tb/tb_present_arb.sv
// Directed bench for present_arb (TIMEOUT=4); the cipher core is played by the
// stimulus, which returns hand-picked result blocks after a chosen latency.
module tb_present_arb;
    logic clk = 1'b0;
    logic iReset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    present_arb_if bus ();

    present_arb #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .iReset_n (iReset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction from IDLE acceptance to response consumption. lat = BUSY
    // cycle on which core_done is raised (0 = never), bp = response stall cycles.
    task automatic xact(input logic w, input logic [63:0] d, input logic [79:0] k,
                        input logic m, input int lat, input logic [63:0] odat,
                        input logic [63:0] exp_rsp, input logic exp_err,
                        input int bp, input bit drop);
        #1;
        chk("req0_ready_idle", bus.req0_ready, !w);
        chk("req1_ready_idle", bus.req1_ready, w);
        @(negedge clk);
        if (drop) begin
            if (w) bus.req1_valid = 1'b0;
            else   bus.req0_valid = 1'b0;
        end
        bus.core_done = 1'b1;
        bus.core_odat = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        chk("grant_load", bus.grant, w);
        chk("core_load_on", bus.core_load, 1'b1);
        chk("busy_load", bus.busy, 1'b1);
        chk("core_idat", bus.core_idat, d);
        chk("core_key", bus.core_key, k);
        chk("core_control", bus.core_control, m);
        chk("ready_load", {bus.req1_ready, bus.req0_ready}, 2'b00);
        @(negedge clk);
        bus.core_done = 1'b0;
        chk("core_load_off", bus.core_load, 1'b0);
        chk("ready_busy", {bus.req1_ready, bus.req0_ready}, 2'b00);
        for (int c = 1; c <= 4; c++) begin
            if (c == lat) begin
                bus.core_done = 1'b1;
                bus.core_odat = odat;
            end
            @(negedge clk);
            bus.core_done = 1'b0;
            bus.core_odat = 64'hFEED_FEED_FEED_FEED;
            if ((c == lat) || (c == 4)) break;
            chk("no_rsp_busy", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        end
        chk("rsp0_valid", bus.rsp0_valid, !w);
        chk("rsp1_valid", bus.rsp1_valid, w);
        chk("rsp_data", bus.rsp_data, exp_rsp);
        chk("rsp_err", bus.rsp_err, exp_err);
        chk("busy_resp", bus.busy, 1'b1);
        bus.rsp0_ready = w;
        bus.rsp1_ready = !w;
        for (int i = 0; i < bp; i++) begin
            bus.core_done = 1'b1;
            bus.core_odat = ~exp_rsp;
            @(negedge clk);
            chk("bp_valid", {bus.rsp1_valid, bus.rsp0_valid}, w ? 2'b10 : 2'b01);
            chk("bp_data", bus.rsp_data, exp_rsp);
            chk("bp_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
            chk("bp_busy", bus.busy, 1'b1);
        end
        bus.core_done  = 1'b0;
        bus.rsp0_ready = !w;
        bus.rsp1_ready = w;
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        chk("rsp_cleared", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        chk("busy_idle", bus.busy, 1'b0);
        chk("grant_kept", bus.grant, w);
    endtask

    task automatic set_req(input logic w, input logic [63:0] d, input logic [79:0] k, input logic m);
        if (w) begin
            bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_key = k; bus.req1_mode = m;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_key = k; bus.req0_mode = m;
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_data  = 64'd0; bus.req1_data = 64'd0;
        bus.req0_key   = 80'd0; bus.req1_key  = 80'd0;
        bus.req0_mode  = 1'b0; bus.req1_mode  = 1'b0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        bus.core_odat  = 64'd0; bus.core_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_grant", bus.grant, 1'b0);
        chk("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        chk("rst_rsp", {bus.rsp_err, bus.rsp_data}, 65'd0);
        chk("rst_core_load", bus.core_load, 1'b0);
        iReset_n = 1'b1;

        // Single encrypt and single decrypt of the all-zero vector.
        set_req(1'b0, 64'h0, 80'h0, 1'b0);
        xact(1'b0, 64'h0, 80'h0, 1'b0, 2, 64'h5579C1387B228445, 64'h5579C1387B228445, 1'b0, 0, 1'b1);
        set_req(1'b1, 64'h5579C1387B228445, 80'h0, 1'b1);
        xact(1'b1, 64'h5579C1387B228445, 80'h0, 1'b1, 1, 64'h0, 64'h0, 1'b0, 0, 1'b1);

        // Contention with both requesters held valid throughout.
        set_req(1'b0, 64'h0123_4567_89AB_CDEF, 80'hA5A5_0000_1111_2222_3333, 1'b0);
        set_req(1'b1, 64'hFEDC_BA98_7654_3210, 80'h5A5A_4444_5555_6666_7777, 1'b1);
        xact(1'b0, 64'h0123_4567_89AB_CDEF, 80'hA5A5_0000_1111_2222_3333, 1'b0, 3, 64'h1111, 64'h1111, 1'b0, 0, 1'b0);
        xact(1'b1, 64'hFEDC_BA98_7654_3210, 80'h5A5A_4444_5555_6666_7777, 1'b1, 2, 64'h2222, 64'h2222, 1'b0, 0, 1'b0);
        xact(1'b0, 64'h0123_4567_89AB_CDEF, 80'hA5A5_0000_1111_2222_3333, 1'b0, 1, 64'h3333, 64'h3333, 1'b0, 0, 1'b0);
        xact(1'b1, 64'hFEDC_BA98_7654_3210, 80'h5A5A_4444_5555_6666_7777, 1'b1, 3, 64'h4444, 64'h4444, 1'b0, 0, 1'b0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Timeout with no core_done, then core_done on the timeout cycle itself.
        set_req(1'b0, 64'hC0FF_EE00_C0FF_EE00, 80'h1, 1'b0);
        xact(1'b0, 64'hC0FF_EE00_C0FF_EE00, 80'h1, 1'b0, 0, 64'h9999, 64'h0, 1'b1, 0, 1'b1);
        set_req(1'b1, 64'hD00D_D00D_D00D_D00D, 80'h2, 1'b1);
        xact(1'b1, 64'hD00D_D00D_D00D_D00D, 80'h2, 1'b1, 4, 64'hE0E0_E0E0_E0E0_E0E0, 64'hE0E0_E0E0_E0E0_E0E0, 1'b0, 0, 1'b1);

        // Response backpressure while req1 waits; req1 is served afterwards.
        set_req(1'b0, 64'hF0F0_F0F0_0F0F_0F0F, 80'h3, 1'b0);
        set_req(1'b1, 64'h1234_0000_5678_0000, 80'h4, 1'b1);
        xact(1'b0, 64'hF0F0_F0F0_0F0F_0F0F, 80'h3, 1'b0, 2, 64'hABCD_EF01_2345_6789, 64'hABCD_EF01_2345_6789, 1'b0, 10, 1'b1);
        xact(1'b1, 64'h1234_0000_5678_0000, 80'h4, 1'b1, 1, 64'h7777, 64'h7777, 1'b0, 0, 1'b1);
        set_req(1'b0, 64'h5555_AAAA_5555_AAAA, 80'h5, 1'b0);
        xact(1'b0, 64'h5555_AAAA_5555_AAAA, 80'h5, 1'b0, 2, 64'h8888_0000_8888, 64'h8888_0000_8888, 1'b0, 0, 1'b1);

        // Reset during BUSY: everything clears and the next tie goes to req0.
        set_req(1'b1, 64'h6666_7777_8888_9999, 80'hFFFF_0000_FFFF_0000_FFFF, 1'b1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", bus.busy, 1'b1);
        iReset_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_grant", bus.grant, 1'b0);
        chk("mid_rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        chk("mid_rst_rsp_data", bus.rsp_data, 64'h0);
        chk("mid_rst_core_idat", bus.core_idat, 64'h0);
        chk("mid_rst_core_key", bus.core_key, 80'h0);
        chk("mid_rst_ctrl_load", {bus.core_control, bus.core_load, bus.rsp_err}, 3'b000);
        @(negedge clk);
        iReset_n = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("post_rst_tie", {bus.req1_ready, bus.req0_ready}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
